// File: rtl/sort_10_stream_ctrl_pkg.sv
// Shared types and constants for the sorting-network stream controller.
package sort_pkg;
  localparam int N_LANES      = 10;
  localparam int SORT_LATENCY = 8;

  typedef logic [31:0] data_t;
  typedef logic [3:0]  cnt_t;

  localparam data_t PAD_VALUE = 32'hFFFF_FFFF;

  typedef struct packed {
    data_t [N_LANES-1:0] lanes;
    cnt_t                k;
  } res_t;

  typedef enum logic {S_GATHER, S_ISSUE} state_t;
endpackage

// File: rtl/sort_10_stream_ctrl_fifo.sv
// Small result buffer holding sorted jobs until they are serialized out.
module sort_result_fifo
  import sort_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  res_t          push_data_i,
  input  logic          pop_i,
  output res_t          head_o,
  output logic [CW-1:0] count_o
);
  res_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    if (rst_n) assert (!(push_i && count_q == CW'(DEPTH)))
      else $error("result buffer overflow on capture");
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/sort_10_stream_ctrl.sv
// Gathers stream words into jobs, issues them to a free-running sorter under
// credit control, and serializes the K smallest sorted words back out.
module sort_10_stream_ctrl
  import sort_pkg::*;
#(
  parameter int RES_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  data_t                  in_data,
  input  logic                   in_last,
  output logic [N_LANES*32-1:0]  srt_in,
  input  logic [N_LANES*32-1:0]  srt_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output data_t                  out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [15:0]            jobs_done
);
  localparam int CW = $clog2(RES_DEPTH + 1);

  state_t                    state_q;
  data_t [N_LANES-1:0]       lanes_q;
  cnt_t                      wr_idx_q, k_q, rd_idx_q;
  logic [SORT_LATENCY-1:0]   vld_pipe_q;
  cnt_t [SORT_LATENCY-1:0]   k_pipe_q;
  logic [15:0]               jobs_done_q;

  logic          accept, close, fire, capture, pop;
  res_t          push_data, head;
  logic [CW-1:0] buf_count;

  assign in_ready = rst_n && (state_q == S_GATHER);
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || wr_idx_q == cnt_t'(N_LANES - 1));
  // Registered counts only: a job still counts until its capture edge, so the
  // buffer always has room when the tracking pipe delivers it.
  assign fire     = (state_q == S_ISSUE) &&
                    (($countones(vld_pipe_q) + 32'(buf_count)) < RES_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_GATHER;
      lanes_q  <= {N_LANES{PAD_VALUE}};
      wr_idx_q <= '0;
      k_q      <= '0;
    end else begin
      case (state_q)
        S_GATHER: if (accept) begin
          lanes_q[wr_idx_q] <= in_data;
          wr_idx_q          <= wr_idx_q + 1'b1;
          if (close) begin
            k_q     <= wr_idx_q + 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: if (fire) begin
          lanes_q  <= {N_LANES{PAD_VALUE}};
          wr_idx_q <= '0;
          state_q  <= S_GATHER;
        end
        default: state_q <= S_GATHER;
      endcase
    end
  end

  assign srt_in = lanes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      k_pipe_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[SORT_LATENCY-2:0], fire};
      k_pipe_q   <= {k_pipe_q[SORT_LATENCY-2:0], k_q};
    end
  end

  assign capture         = vld_pipe_q[SORT_LATENCY-1];
  assign push_data.lanes = srt_out;
  assign push_data.k     = k_pipe_q[SORT_LATENCY-1];

  sort_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (capture),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (buf_count)
  );

  assign out_valid = (buf_count != '0);
  assign out_last  = out_valid && (rd_idx_q == head.k - 4'd1);
  assign out_data  = out_valid ? head.lanes[rd_idx_q] : '0;
  assign pop       = out_valid && out_ready && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_q    <= '0;
      jobs_done_q <= '0;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        rd_idx_q    <= '0;
        jobs_done_q <= jobs_done_q + 16'd1;
      end else begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
    end
  end

  assign jobs_done = jobs_done_q;
  assign busy      = (state_q == S_ISSUE) || (wr_idx_q != '0) ||
                     (|vld_pipe_q) || (buf_count != '0);
endmodule

// File: doc/sort_10_stream_ctrl.md
# sort_10_stream_ctrl

Streaming front-end and sequencer for the 10-input, 8-stage pipelined sorting network. It gathers words from a valid/ready input stream into 10-word jobs, padding short jobs, and fires each job into the free-running sorter for exactly one cycle. It tracks jobs in flight with a latency-aligned valid/count shift register and captures sorted results into a small result buffer. The sorter itself has no enable and no backpressure, so the block uses credit-based issue so that no result is ever lost, then serializes each result onto a valid/ready output stream.

## Interface
- `N_LANES`, 10: sorter width, in words.
- `SORT_LATENCY`, 8: cycles from sorter input sample to output valid.
- `RES_DEPTH`, 2: result buffer entries; this is also the credit limit.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: input word accepted when `in_valid && in_ready`.
- `in_data` in 32: input word, unsigned.
- `in_last` in 1: closes the current job early (job length 1..10).
- `srt_in` out 320: to sorter `data_0..data_9`; lane i is bits [32i+31:32i].
- `srt_out` in 320: from sorter `sort_0..sort_9`, same packing.
- `out_valid` out 1: sorted word valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 32: sorted word, ascending.
- `out_last` out 1: last word of the job.
- `busy` out 1: any job is gathering, in flight, or buffered.
- `jobs_done` out 16: count of jobs fully drained; wraps.

## Operation
- FSM states: GATHER, ISSUE.
- **GATHER**
  - `in_ready`=1.
  - Each accepted word is written to lane `wr_idx`, and `wr_idx` increments.
  - The job closes on the 10th word or on `in_last`. On close, latch K = words in the job (1..10) and go to ISSUE.
- **ISSUE**
  - `in_ready`=0.
  - The state waits while `inflight + buf_count >= RES_DEPTH`.
  - When credit is available, assert an internal `fire` for one cycle. `srt_in` already holds the gathered lanes, and the sorter samples it on the edge ending the fire cycle.
  - In that same cycle, reset all lanes to 0xFFFFFFFF, set `wr_idx`=0, and return to GATHER.
- Padding:
  - Unwritten lanes hold 0xFFFFFFFF, so the K smallest outputs are exactly the K real words, including ties with a genuine 0xFFFFFFFF.
  - Only lanes 0..K-1 of the result are emitted.
- Tracking: a shift register of SORT_LATENCY stages, each holding {valid, K}. It is loaded with {fire, K} and shifted every cycle.
- Capture: when the last stage is valid, write `srt_out` and its K into the result buffer. By construction of the credits the buffer is never full at capture; the verification engineer asserts this.
- Drain:
  - The head entry is emitted from `rd_idx` 0..K-1, and `out_last` is asserted when `rd_idx`=K-1.
  - On the `out_last` handshake, pop the entry and increment `jobs_done`.
- `inflight` is the number of valid tracking stages.
- Fire, capture and pop may coincide in one cycle, and the credit arithmetic uses the registered counts.
- `in_data` is ignored while `in_ready`=0.
- An `in_last` on the 10th word is a normal close. Words beyond 10 without `in_last` start a new job.

## Timing
- The sorter's own stage registers are not reset. Undefined contents in the sorter are harmless because every tracking stage is cleared by reset.
- Reset values:
  - `in_ready` 0 while `rst_n` is low, then 1 (state GATHER).
  - `out_valid` 0, `out_last` 0, `out_data` 0.
  - `srt_in` all 0xFFFFFFFF.
  - `busy` 0, `jobs_done` 0.
  - Tracking register and result buffer empty.
- Reset mid-job: the partial gather and all in-flight and buffered jobs are discarded with no output.
- Full job accepted in cycles 0..9:
  - fire in cycle 10;
  - sorter output valid, and capture, in cycle 18;
  - `out_valid` with word 0 in cycle 19;
  - `out_last` in cycle 28 if `out_ready` is held high.
- Sustained input throughput is 1 job per K+1 cycles while credit is available.
- `out_data`, `out_valid` and `out_last` are driven from the registered buffer head and index, with no combinational path from `in_*`.

## Structure
- Package `sort_pkg` holds:
  - `data_t` (32-bit);
  - `N_LANES`=10;
  - `SORT_LATENCY`=8;
  - `PAD_VALUE`=32'hFFFF_FFFF;
  - the lane-count type (4 bits).
- Sub-module `sort_result_fifo`: a RES_DEPTH-entry FIFO of {10×data_t, K} with push, pop and count. It uses the same clock and asynchronous reset.
- The sorter is instantiated beside this block at the top level, not inside it.

## Test plan
- **Full job.** Input 10 words 9,3,7,0,5,1,8,2,6,4, then continuous `out_ready`. Required: `out_data` 0..9 over cycles 19..28, `out_last` on 9, `jobs_done`=1.
- **Short job.** Input 3 words 0xFFFFFFFF,5,5 with `in_last` on the 3rd. Required: output 5, 5, 0xFFFFFFFF with `out_last` on the 3rd, and exactly 3 beats.
- **Backpressure.** Hold `out_ready`=0 and send 3 full jobs. Required:
  - jobs 1 and 2 fire;
  - job 3 stays in ISSUE with `in_ready`=0;
  - after `out_ready` rises, job 3 fires only after job 1's `out_last` handshake;
  - all 30 words come out, correctly ordered per job.
- **Back-to-back.** Send 20 random full jobs with `out_ready` toggling pseudo-randomly. Required: every job's output is the sorted multiset of its input, and job order is preserved.
- **Reset mid-flight.** Assert `rst_n` low 4 cycles after a fire. Required: all outputs at their reset values, no stale beat after release, and the next job sorts correctly.
- **Simultaneous events.** Arrange for fire, capture and pop to coincide in one cycle. Required: credit count correct, no overflow assertion, and no lost or duplicated job.
